toast_dmem: RTL and testbench

Data-memory subsystem sitting directly downstream of the RV32I core's MEM stage: it consumes the core's DMEM port (`DMEM_addr`, byte enables, write data, write enable, output-register reset) and returns `DMEM_rd_data`. It contains a byte-writable synchronous word RAM, a 64-bit cycle counter with a snapshot register, and a byte-wide TX FIFO drained over a valid/ready stream. All three are decoded from a single 32-bit address space.

---
 rtl/toast_dmem_pkg.sv | 27 ++
 rtl/toast_dmem_if.sv | 25 ++
 rtl/toast_sync_fifo.sv | 74 +++++++
 rtl/toast_dmem.sv | 135 +++++++++++++
 tb/tb_toast_dmem.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/toast_dmem_pkg.sv
// Shared definitions for the toast_dmem data-memory subsystem:
// MMIO register map, TXSTAT field layout and the address-decode result.
package toast_dmem_pkg;

   localparam logic [7:0] OFF_TXDATA = 8'h00;
   localparam logic [7:0] OFF_TXSTAT = 8'h04;
   localparam logic [7:0] OFF_CYC_LO = 8'h08;
   localparam logic [7:0] OFF_CYC_HI = 8'h0C;

   // Address bits [1:0] are ignored, so registers are matched on word offset.
   localparam logic [5:0] WORD_TXDATA = OFF_TXDATA[7:2];
   localparam logic [5:0] WORD_TXSTAT = OFF_TXSTAT[7:2];
   localparam logic [5:0] WORD_CYC_LO = OFF_CYC_LO[7:2];
   localparam logic [5:0] WORD_CYC_HI = OFF_CYC_HI[7:2];

   localparam int TXSTAT_OVF_BIT   = 7;
   localparam int TXSTAT_FULL_BIT  = 6;
   localparam int TXSTAT_EMPTY_BIT = 5;
   localparam int TXSTAT_CNT_W     = 5;

   typedef enum logic [1:0] {
      DEC_RAM,
      DEC_MMIO,
      DEC_NONE
   } dec_e;

endpackage

// File: rtl/toast_dmem_if.sv
// DMEM port from the core's MEM stage plus the TX byte stream and bus-error flag.
interface toast_dmem_if;

   logic [31:0] DMEM_addr;
   logic [3:0]  DMEM_wr_byte_en;
   logic        DMEM_wr_en;
   logic [31:0] DMEM_wr_data;
   logic        DMEM_rst;
   logic [31:0] DMEM_rd_data;
   logic [7:0]  Tx_data;
   logic        Tx_valid;
   logic        Tx_ready;
   logic        Bus_error;

   modport master (
      output DMEM_addr, DMEM_wr_byte_en, DMEM_wr_en, DMEM_wr_data, DMEM_rst, Tx_ready,
      input  DMEM_rd_data, Tx_data, Tx_valid, Bus_error
   );

   modport slave (
      input  DMEM_addr, DMEM_wr_byte_en, DMEM_wr_en, DMEM_wr_data, DMEM_rst, Tx_ready,
      output DMEM_rd_data, Tx_data, Tx_valid, Bus_error
   );

endinterface

// File: rtl/toast_sync_fifo.sv
// Register-array synchronous FIFO; head is read combinationally at the read pointer.
// A push while full is accepted only if a pop frees a slot on the same edge.
module toast_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop_req,
   output logic [WIDTH-1:0]         head_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     push_drop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             pop;
   logic             push_ok;

   always_comb begin
      pop       = pop_req && (count_q != '0);
      push_ok   = push && ((count_q != FULL_CNT) || pop);
      push_drop = push && !push_ok;
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Array is reset so the head byte reads 0 out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign empty     = (count_q == '0);
   assign full      = (count_q == FULL_CNT);
   assign count     = count_q;

endmodule

// File: rtl/toast_dmem.sv
// Data-memory subsystem: byte-writable word RAM, 64-bit cycle counter with
// snapshot, and a TX byte FIFO, all behind one decoded address space.
module toast_dmem
   import toast_dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
   input logic         Clk,
   input logic         Reset_n,
   toast_dmem_if.slave bus
);

   localparam int          RAM_AW    = $clog2(DEPTH_WORDS);
   localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [32:0] RAM_LIMIT = 33'(DEPTH_WORDS) << 2;

   dec_e              dec;
   logic [5:0]        mmio_word;
   logic              is_txdata, is_txstat, is_cyc_lo, is_cyc_hi;
   logic              wr_any;
   logic [RAM_AW-1:0] ram_idx;
   logic [3:0]        ram_we;
   logic [31:0]       ram_q [DEPTH_WORDS];

   logic [31:0]       rd_data_q, rd_data_d;
   logic              bus_err_q, bus_err_d;
   logic              ovf_q, ovf_d;
   logic [63:0]       cyc_q, cyc_d;
   logic [63:0]       shadow_q, shadow_d;
   logic [7:0]        txstat;

   logic              fifo_push, fifo_drop, fifo_empty, fifo_full;
   logic [CNT_W-1:0]  fifo_count;
   logic [7:0]        fifo_head;

   always_comb begin
      dec = DEC_NONE;
      if ({1'b0, bus.DMEM_addr} < RAM_LIMIT) begin
         dec = DEC_RAM;
      end else if (bus.DMEM_addr[31:8] == MMIO_BASE[31:8]) begin
         dec = DEC_MMIO;
      end
      mmio_word = bus.DMEM_addr[7:2];
      ram_idx   = bus.DMEM_addr[RAM_AW+1:2];
      is_txdata = (dec == DEC_MMIO) && (mmio_word == WORD_TXDATA);
      is_txstat = (dec == DEC_MMIO) && (mmio_word == WORD_TXSTAT);
      is_cyc_lo = (dec == DEC_MMIO) && (mmio_word == WORD_CYC_LO);
      is_cyc_hi = (dec == DEC_MMIO) && (mmio_word == WORD_CYC_HI);
      wr_any    = bus.DMEM_wr_en && (|bus.DMEM_wr_byte_en);
      bus_err_d = wr_any && ((dec == DEC_NONE) ||
                  ((dec == DEC_MMIO) && !(is_txdata || is_txstat || is_cyc_lo || is_cyc_hi)));
      ram_we    = (bus.DMEM_wr_en && (dec == DEC_RAM)) ? bus.DMEM_wr_byte_en : 4'b0000;
      fifo_push = bus.DMEM_wr_en && is_txdata && bus.DMEM_wr_byte_en[0];
   end

   // Register state updates; clear and drop come from different addresses so never collide.
   always_comb begin
      ovf_d = ovf_q;
      if (wr_any && is_txstat && bus.DMEM_wr_data[TXSTAT_OVF_BIT]) begin
         ovf_d = 1'b0;
      end else if (fifo_drop) begin
         ovf_d = 1'b1;
      end
      cyc_d    = cyc_q + 64'd1;
      shadow_d = (wr_any && is_cyc_lo) ? cyc_q : shadow_q;

      txstat                   = '0;
      txstat[TXSTAT_OVF_BIT]   = ovf_q;
      txstat[TXSTAT_FULL_BIT]  = fifo_full;
      txstat[TXSTAT_EMPTY_BIT] = fifo_empty;
      txstat[TXSTAT_CNT_W-1:0] = TXSTAT_CNT_W'(fifo_count);

      rd_data_d = '0;
      if (!bus.DMEM_rst) begin
         if (dec == DEC_RAM) begin
            rd_data_d = ram_q[ram_idx];
         end else if (is_txstat) begin
            rd_data_d = {24'b0, txstat};
         end else if (is_cyc_lo) begin
            rd_data_d = shadow_q[31:0];
         end else if (is_cyc_hi) begin
            rd_data_d = shadow_q[63:32];
         end
      end
   end

   // RAM contents are deliberately not reset; read mux above sees pre-edge data (read-first).
   always_ff @(posedge Clk) begin
      for (int i = 0; i < 4; i++) begin
         if (ram_we[i]) begin
            ram_q[ram_idx][8*i +: 8] <= bus.DMEM_wr_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rd_data_q <= '0;
         bus_err_q <= 1'b0;
         ovf_q     <= 1'b0;
         cyc_q     <= '0;
         shadow_q  <= '0;
      end else begin
         rd_data_q <= rd_data_d;
         bus_err_q <= bus_err_d;
         ovf_q     <= ovf_d;
         cyc_q     <= cyc_d;
         shadow_q  <= shadow_d;
      end
   end

   toast_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk       (Clk),
      .rst_n     (Reset_n),
      .push      (fifo_push),
      .push_data (bus.DMEM_wr_data[7:0]),
      .pop_req   (bus.Tx_ready),
      .head_data (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count),
      .push_drop (fifo_drop)
   );

   assign bus.DMEM_rd_data = rd_data_q;
   assign bus.Bus_error    = bus_err_q;
   assign bus.Tx_data      = fifo_head;
   assign bus.Tx_valid     = !fifo_empty;

endmodule

// File: tb/tb_toast_dmem.sv
// Directed bench for toast_dmem: a vector table for RAM/decode behaviour plus
// hand-written sequences for snapshot, FIFO overflow/drain and reset.
module tb_toast_dmem;

   localparam logic [31:0] MB      = 32'h8000_0000;
   localparam logic [31:0] A_TXDAT = MB + 32'h00;
   localparam logic [31:0] A_TXST  = MB + 32'h04;
   localparam logic [31:0] A_CYLO  = MB + 32'h08;
   localparam logic [31:0] A_CYHI  = MB + 32'h0C;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   toast_dmem_if dif();

   toast_dmem #(
      .DEPTH_WORDS (1024),
      .FIFO_DEPTH  (8),
      .MMIO_BASE   (MB)
   ) dut (
      .Clk     (clk),
      .Reset_n (rst_n),
      .bus     (dif)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
      logic        drst;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string n, input logic [31:0] a, input logic [3:0] be,
                               input logic we, input logic [31:0] d, input logic drst,
                               input logic chk, input logic [31:0] er, input logic ee);
      vec_t v;
      v.name = n; v.addr = a; v.be = be; v.we = we; v.wdata = d; v.drst = drst;
      v.chk_rd = chk; v.exp_rd = er; v.exp_err = ee;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [3:0] be, input logic we,
                        input logic [31:0] d, input logic drst);
      dif.DMEM_addr       = a;
      dif.DMEM_wr_byte_en = be;
      dif.DMEM_wr_en      = we;
      dif.DMEM_wr_data    = d;
      dif.DMEM_rst        = drst;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_steps(input int n);
      drive(32'h0, 4'b0000, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] exp_bytes [8];

      drive(32'h0, 4'b0000, 1'b0, 32'h0, 1'b0);
      dif.Tx_ready = 1'b0;

      vecs.push_back(mk("ram0_init",    32'h0000_0000, 4'hF, 1, 32'hCAFE_F00D, 0, 0, 32'h0, 0));
      vecs.push_back(mk("ram10_full",   32'h0000_0010, 4'hF, 1, 32'hAABB_CCDD, 0, 0, 32'h0, 0));
      vecs.push_back(mk("ram10_lane2",  32'h0000_0010, 4'h4, 1, 32'h00EE_0000, 0, 1, 32'hAABB_CCDD, 0));
      vecs.push_back(mk("ram10_rd",     32'h0000_0010, 4'h0, 0, 32'h0, 0, 1, 32'hAAEE_CCDD, 0));
      vecs.push_back(mk("ram20_init",   32'h0000_0020, 4'hF, 1, 32'h0, 0, 0, 32'h0, 0));
      vecs.push_back(mk("ram20_rfirst", 32'h0000_0020, 4'hF, 1, 32'h1111_1111, 0, 1, 32'h0, 0));
      vecs.push_back(mk("ram20_dmemrst",32'h0000_0020, 4'h0, 0, 32'h0, 1, 1, 32'h0, 0));
      vecs.push_back(mk("ram20_rd",     32'h0000_0020, 4'h0, 0, 32'h0, 0, 1, 32'h1111_1111, 0));
      vecs.push_back(mk("ramtop_wr",    32'h0000_0FFC, 4'hF, 1, 32'h1234_5678, 0, 0, 32'h0, 0));
      vecs.push_back(mk("ramtop_rd",    32'h0000_0FFC, 4'h0, 0, 32'h0, 0, 1, 32'h1234_5678, 0));
      vecs.push_back(mk("ramlim_wr",    32'h0000_1000, 4'hF, 1, 32'hDEAD_BEEF, 0, 1, 32'h0, 1));
      vecs.push_back(mk("ram0_rd",      32'h0000_0000, 4'h0, 0, 32'h0, 0, 1, 32'hCAFE_F00D, 0));
      vecs.push_back(mk("undec_wr",     32'h4000_0000, 4'hF, 1, 32'hDEAD_BEEF, 0, 1, 32'h0, 1));
      vecs.push_back(mk("undec_after",  32'h0000_0010, 4'h0, 0, 32'h0, 0, 1, 32'hAAEE_CCDD, 0));
      vecs.push_back(mk("mmio40_wr",    MB + 32'h40,   4'hF, 1, 32'h0000_0080, 0, 1, 32'h0, 1));
      vecs.push_back(mk("txstat_rd",    A_TXST,        4'h0, 0, 32'h0, 0, 1, 32'h0000_0020, 0));
      vecs.push_back(mk("undec_rd",     32'h4000_0000, 4'h0, 0, 32'h0, 0, 1, 32'h0, 0));
      vecs.push_back(mk("noben_undec",  32'h4000_0000, 4'h0, 1, 32'hFFFF_FFFF, 0, 1, 32'h0, 0));
      vecs.push_back(mk("noben_ram",    32'h0000_0010, 4'h0, 1, 32'h0, 0, 1, 32'hAAEE_CCDD, 0));
      vecs.push_back(mk("cychi_wr",     A_CYHI,        4'hF, 1, 32'hFFFF_FFFF, 0, 1, 32'h0, 0));
      vecs.push_back(mk("cylo_rd",      A_CYLO,        4'h0, 0, 32'h0, 0, 1, 32'd100, 0));
      vecs.push_back(mk("cyhi_rd",      A_CYHI,        4'h0, 0, 32'h0, 0, 1, 32'h0, 0));

      // Reset values while held in reset
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rd_data", dif.DMEM_rd_data, 32'h0);
      chk("rst_tx_valid", 32'(dif.Tx_valid), 32'h0);
      chk("rst_tx_data", 32'(dif.Tx_data), 32'h0);
      chk("rst_bus_error", 32'(dif.Bus_error), 32'h0);
      rst_n = 1'b1;

      // Snapshot after 100 counted edges captures the pre-edge value 100
      idle_steps(100);
      drive(A_CYLO, 4'hF, 1'b1, 32'h0, 1'b0);
      step();
      drive(A_CYLO, 4'h0, 1'b0, 32'h0, 1'b0);
      step();
      chk("snap_lo", dif.DMEM_rd_data, 32'd100);
      drive(A_CYHI, 4'h0, 1'b0, 32'h0, 1'b0);
      step();
      chk("snap_hi", dif.DMEM_rd_data, 32'h0);
      idle_steps(20);
      drive(A_CYLO, 4'h0, 1'b0, 32'h0, 1'b0);
      step();
      chk("snap_lo_hold", dif.DMEM_rd_data, 32'd100);

      foreach (vecs[i]) begin
         drive(vecs[i].addr, vecs[i].be, vecs[i].we, vecs[i].wdata, vecs[i].drst);
         step();
         if (vecs[i].chk_rd) chk({vecs[i].name, "_rd"}, dif.DMEM_rd_data, vecs[i].exp_rd);
         chk({vecs[i].name, "_err"}, 32'(dif.Bus_error), 32'(vecs[i].exp_err));
      end

      // FIFO overflow, W1C and drain
      dif.Tx_ready = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         drive(A_TXDAT, 4'b0001, 1'b1, 32'(i), 1'b0);
         step();
         if (i == 1) begin
            chk("push1_valid", 32'(dif.Tx_valid), 32'h1);
            chk("push1_data", 32'(dif.Tx_data), 32'h01);
         end
      end
      drive(A_TXST, 4'h0, 1'b0, 32'h0, 1'b0);
      step();
      chk("txstat_ovf", dif.DMEM_rd_data, 32'h0000_00C8);
      drive(A_TXST, 4'hF, 1'b1, 32'h0000_0080, 1'b0);
      step();
      drive(A_TXST, 4'h0, 1'b0, 32'h0, 1'b0);
      step();
      chk("txstat_w1c", dif.DMEM_rd_data, 32'h0000_0048);
      drive(32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
      dif.Tx_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         chk($sformatf("drain%0d_valid", k), 32'(dif.Tx_valid), 32'h1);
         chk($sformatf("drain%0d_data", k), 32'(dif.Tx_data), 32'(k));
         step();
      end
      chk("drain_empty", 32'(dif.Tx_valid), 32'h0);
      dif.Tx_ready = 1'b0;
      drive(A_TXST, 4'h0, 1'b0, 32'h0, 1'b0);
      step();
      chk("txstat_empty", dif.DMEM_rd_data, 32'h0000_0020);

      // Push and pop on the same edge while full
      for (int i = 0; i < 8; i++) begin
         drive(A_TXDAT, 4'b0001, 1'b1, 32'h11 + 32'(i), 1'b0);
         step();
      end
      chk("full_head", 32'(dif.Tx_data), 32'h11);
      dif.Tx_ready = 1'b1;
      drive(A_TXDAT, 4'b0001, 1'b1, 32'h5A, 1'b0);
      step();
      dif.Tx_ready = 1'b0;
      drive(A_TXST, 4'h0, 1'b0, 32'h0, 1'b0);
      step();
      chk("pushpop_full_stat", dif.DMEM_rd_data, 32'h0000_0048);
      exp_bytes = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h5A};
      drive(32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
      dif.Tx_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("pp_drain%0d", k), 32'(dif.Tx_data), 32'(exp_bytes[k]));
         step();
      end
      chk("pp_empty", 32'(dif.Tx_valid), 32'h0);

      // Push while empty with Tx_ready high: only the push lands
      drive(A_TXDAT, 4'b0001, 1'b1, 32'h77, 1'b0);
      step();
      chk("empty_pp_valid", 32'(dif.Tx_valid), 32'h1);
      chk("empty_pp_data", 32'(dif.Tx_data), 32'h77);
      drive(32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
      step();
      chk("empty_pp_popped", 32'(dif.Tx_valid), 32'h0);

      // Asynchronous reset mid-operation
      dif.Tx_ready = 1'b0;
      drive(A_TXDAT, 4'b0001, 1'b1, 32'h99, 1'b0);
      step();
      drive(32'h0000_0010, 4'h0, 1'b0, 32'h0, 1'b0);
      step();
      chk("pre_rst_valid", 32'(dif.Tx_valid), 32'h1);
      chk("pre_rst_rd", dif.DMEM_rd_data, 32'hAAEE_CCDD);
      dif.Tx_ready = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(dif.Tx_valid), 32'h0);
      chk("async_rst_data", 32'(dif.Tx_data), 32'h0);
      chk("async_rst_rd", dif.DMEM_rd_data, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      dif.Tx_ready = 1'b0;
      drive(A_TXST, 4'h0, 1'b0, 32'h0, 1'b0);
      step();
      chk("post_rst_txstat", dif.DMEM_rd_data, 32'h0000_0020);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
